logistic_orbit_scheduler: RTL and testbench



---
 rtl/logistic_pkg.sv | 23 ++
 rtl/logistic_orbit_scheduler_bank.sv | 48 ++++
 rtl/logistic_orbit_scheduler.sv | 168 ++++++++++++++++
 tb/tb_logistic_orbit_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logistic_pkg.sv
// Shared types and constants for the logistic orbit scheduler.
package logistic_pkg;

    localparam int X_W  = 17;
    localparam int MU_W = 18;
    localparam logic [X_W-1:0] ONE_Q16 = 17'h10000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_RELEASE,
        S_ADVANCE,
        S_FIN
    } sched_state_t;

    // Seed of channel idx: base + idx, wrapping in Q1.16.
    function automatic logic [X_W-1:0] seed_of(input logic [X_W-1:0] base, input int idx);
        return base + X_W'(idx);
    endfunction

endpackage

// File: rtl/logistic_orbit_scheduler_bank.sv
// orbit_state_bank: NCH x 17-bit channel state registers.
// One write port (seed all channels, or write one channel), two read ports.
module orbit_state_bank
    import logistic_pkg::*;
#(
    parameter int NCH = 7
)
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_seed_all,
    input  logic [X_W-1:0]   i_dzero,
    input  logic             i_wr_en,
    input  logic [3:0]       i_wr_ch,
    input  logic [X_W-1:0]   i_wr_data,
    input  logic [3:0]       i_fu_sel,
    output logic [X_W-1:0]   o_fu_x,
    input  logic [3:0]       i_rd_sel,
    output logic [X_W-1:0]   o_rd_data
);

    logic [X_W-1:0] r_mem [NCH];

    // Seeding takes priority over a single-channel write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NCH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (i_seed_all)
                    r_mem[i] <= seed_of(i_dzero, i);
                else if (i_wr_en && (i_wr_ch == 4'(i)))
                    r_mem[i] <= i_wr_data;
            end
        end
    end

    // Read muxes; unmatched selects (>= NCH) return 0.
    always_comb begin
        o_fu_x    = '0;
        o_rd_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (i_fu_sel == 4'(i)) o_fu_x    = r_mem[i];
            if (i_rd_sel == 4'(i)) o_rd_data = r_mem[i];
        end
    end

endmodule

// File: rtl/logistic_orbit_scheduler.sv
// logistic_orbit_scheduler: time-shares one logistic-map unit across NCH
// orbit channels, round-robin, for a latched number of rounds.
// Optional macro LOGISTIC_SCHED_TIMEOUT_EN adds a per-evaluation timeout
// that aborts the run and raises err.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_LOAD    | seed every channel, clear channel/round counters
// S_ISSUE   | wait for fu_done low, then present x and raise fu_start
// S_WAIT    | fu_start held until fu_done, result captured
// S_RELEASE | wait for fu_done to drop
// S_ADVANCE | step channel / round, decide finish
// S_FIN     | pulse done, drop busy
module logistic_orbit_scheduler
    import logistic_pkg::*;
#(
    parameter int NCH     = 7,
    parameter int TIMEOUT = 255
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [X_W-1:0]    dzero,
    input  logic [MU_W-1:0]   mu,
    input  logic [8:0]        times,
    output logic              busy,
    output logic              done,
    output logic              fu_start,
    output logic [X_W-1:0]    fu_x,
    output logic [MU_W-1:0]   fu_mu,
    input  logic              fu_done,
    input  logic [X_W-1:0]    fu_y,
    input  logic [3:0]        rd_sel,
    output logic [X_W-1:0]    rd_data,
    output logic              err
);

`ifdef LOGISTIC_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    sched_state_t     r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_fu_start;
    logic [X_W-1:0]   r_fu_x;
    logic [MU_W-1:0]  r_fu_mu;
    logic             r_err;
    logic [8:0]       r_times;
    logic [8:0]       r_round;
    logic [3:0]       r_ch;
    logic [15:0]      r_to_cnt;

    logic             w_seed_all;
    logic             w_wr_en;
    logic [X_W-1:0]   w_bank_x;
    logic             w_to_hit;

    assign w_seed_all = (r_state == S_LOAD);
    assign w_wr_en    = (r_state == S_WAIT) && fu_done;
    assign w_to_hit   = TO_EN && (r_to_cnt == 16'(TIMEOUT - 1));

    orbit_state_bank #(.NCH(NCH)) u_bank (
        .CLK        (CLK),
        .RST        (RST),
        .i_seed_all (w_seed_all),
        .i_dzero    (dzero),
        .i_wr_en    (w_wr_en),
        .i_wr_ch    (r_ch),
        .i_wr_data  (fu_y),
        .i_fu_sel   (r_ch),
        .o_fu_x     (w_bank_x),
        .i_rd_sel   (rd_sel),
        .o_rd_data  (rd_data)
    );

    // Scheduler FSM with registered handshake and status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fu_start <= 1'b0;
            r_fu_x     <= '0;
            r_fu_mu    <= '0;
            r_err      <= 1'b0;
            r_times    <= '0;
            r_round    <= '0;
            r_ch       <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_fu_mu <= mu;
                        r_times <= times;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_ch    <= '0;
                    r_round <= '0;
                    r_state <= (r_times == 9'd0) ? S_FIN : S_ISSUE;
                end
                S_ISSUE: begin
                    r_to_cnt <= '0;
                    if (!fu_done) begin
                        r_fu_x     <= w_bank_x;
                        r_fu_start <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (fu_done) begin
                        r_fu_start <= 1'b0;
                        r_state    <= S_RELEASE;
                    end else if (w_to_hit) begin
                        r_fu_start <= 1'b0;
                        r_err      <= 1'b1;
                        r_state    <= S_FIN;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end
                S_RELEASE: begin
                    if (!fu_done) begin
                        r_state <= S_ADVANCE;
                    end else if (w_to_hit) begin
                        r_err   <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end
                S_ADVANCE: begin
                    if (r_ch == 4'(NCH - 1)) begin
                        r_ch    <= '0;
                        r_round <= r_round + 9'd1;
                        r_state <= (r_round + 9'd1 == r_times) ? S_FIN : S_ISSUE;
                    end else begin
                        r_ch    <= r_ch + 4'd1;
                        r_state <= S_ISSUE;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign fu_start = r_fu_start;
    assign fu_x     = r_fu_x;
    assign fu_mu    = r_fu_mu;
    assign err      = r_err;

endmodule

// File: tb/tb_logistic_orbit_scheduler.sv
// Directed bench for logistic_orbit_scheduler with a behavioural
// 4-cycle logistic-map unit on the fu_* handshake.
module tb_logistic_orbit_scheduler;

    localparam int NCH = 7;
    localparam int LAT = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [16:0] dzero;
    logic [17:0] mu;
    logic [8:0]  times;
    logic        busy, done, fu_start, err;
    logic [16:0] fu_x;
    logic [17:0] fu_mu;
    logic        fu_done;
    logic [16:0] fu_y;
    logic [3:0]  rd_sel;
    logic [16:0] rd_data;

    int  n_err = 0;
    int  n_chk = 0;
    int  n_starts = 0;
    int  n_done = 0;
    int  n_viol = 0;
    bit  unit_en = 1'b1;
    bit  hold_extra = 1'b0;

    logistic_orbit_scheduler #(.NCH(NCH), .TIMEOUT(10)) dut (
        .CLK(CLK), .RST(RST), .start(start), .dzero(dzero), .mu(mu), .times(times),
        .busy(busy), .done(done), .fu_start(fu_start), .fu_x(fu_x), .fu_mu(fu_mu),
        .fu_done(fu_done), .fu_y(fu_y), .rd_sel(rd_sel), .rd_data(rd_data), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] unit_y(input logic [16:0] x, input logic [17:0] m);
        logic [16:0] omx;
        logic [33:0] term;
        logic [35:0] p;
        omx  = 17'h10000 - x;
        term = {17'b0, x} * {17'b0, omx};
        p    = {18'b0, m} * {18'b0, term[33:16]};
        return p[32:16];
    endfunction

    task automatic read_ch(input int i, output logic [16:0] v);
        rd_sel = 4'(i);
        #1;
        v = rd_data;
    endtask

    // Evaluation unit model: answers fu_start after LAT edges, holds fu_done
    // until fu_start drops (plus one cycle when hold_extra).
    initial begin
        fu_done = 1'b0;
        fu_y    = '0;
        forever begin
            @(posedge CLK); #1;
            if (!RST && unit_en && fu_start && !fu_done) begin
                for (int k = 0; k < LAT - 1 && !RST; k++) begin
                    @(posedge CLK); #1;
                end
                if (!RST) begin
                    fu_y    = unit_y(fu_x, fu_mu);
                    fu_done = 1'b1;
                    for (int k = 0; k < 1000 && fu_start && !RST; k++) begin
                        @(posedge CLK); #1;
                    end
                    if (hold_extra && !RST) begin
                        @(posedge CLK); #1;
                    end
                end
                fu_done = 1'b0;
            end
        end
    end

    // Protocol monitor on the falling edge.
    logic        prev_start = 1'b0;
    logic        prev_done  = 1'b0;
    logic [16:0] prev_x     = '0;
    logic [17:0] prev_mu    = '0;
    always @(negedge CLK) begin
        if (fu_start && !prev_start) begin
            n_starts++;
            if (fu_done) n_viol++;
        end
        if (fu_start && prev_start && (fu_x != prev_x || fu_mu != prev_mu)) n_viol++;
        if (done) n_done++;
        if (done && prev_done) n_viol++;
        prev_start = fu_start;
        prev_done  = done;
        prev_x     = fu_x;
        prev_mu    = fu_mu;
    end

    task automatic run_case(input string tag, input logic [16:0] dz, input logic [17:0] m,
                            input logic [8:0] t, input bit poke, output int cyc);
        int s0, d0;
        logic [16:0] exp_st [NCH];
        logic [16:0] v;
        s0 = n_starts;
        d0 = n_done;
        dzero = dz; mu = m; times = t; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 5000) begin
            if (poke && cyc == 12) begin
                start = 1'b1; mu = 18'h3FFFF; times = 9'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        start = 1'b0; mu = m; times = t;
        check({tag, " done"}, 36'(done), 36'd1);
        check({tag, " fu_start at done"}, 36'(fu_start), 36'd0);
        repeat (3) @(posedge CLK);
        #1;
        check({tag, " busy after"}, 36'(busy), 36'd0);
        check({tag, " done pulses"}, 36'(n_done - d0), 36'd1);
        check({tag, " evals"}, 36'(n_starts - s0), 36'(NCH * int'(t)));
        for (int i = 0; i < NCH; i++) exp_st[i] = dz + 17'(i);
        for (int r = 0; r < int'(t); r++)
            for (int i = 0; i < NCH; i++) exp_st[i] = unit_y(exp_st[i], m);
        for (int i = 0; i < NCH; i++) begin
            read_ch(i, v);
            check($sformatf("%s ch%0d", tag, i), 36'(v), 36'(exp_st[i]));
        end
    endtask

    initial begin
        int cyc, s0;
        logic [16:0] v;
        RST = 1'b1; start = 1'b0; dzero = '0; mu = '0; times = '0; rd_sel = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst busy", 36'(busy), 36'd0);
        check("rst done", 36'(done), 36'd0);
        check("rst fu_start", 36'(fu_start), 36'd0);
        check("rst fu_x", 36'(fu_x), 36'd0);
        check("rst fu_mu", 36'(fu_mu), 36'd0);
        check("rst err", 36'(err), 36'd0);
        read_ch(3, v);
        check("rst ch3", 36'(v), 36'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Fixed point at 0.5 with mu=2.0.
        run_case("fix", 17'h08000, 18'h20000, 9'd3, 1'b0, cyc);
        read_ch(0, v);
        check("fix ch0 const", 36'(v), 36'h08000);
        check("fix handshakes", 36'(n_starts), 36'd21);

        // mu=0 collapses every channel to zero in one round.
        run_case("mu0", 17'h12345, 18'h00000, 9'd1, 1'b0, cyc);
        read_ch(6, v);
        check("mu0 ch6 const", 36'(v), 36'd0);

        // times=0: seeds only, with wrap on the top channel.
        s0 = n_starts;
        run_case("t0", 17'h1FFFC, 18'h2AAAA, 9'd0, 1'b0, cyc);
        check("t0 latency", 36'(cyc), 36'd3);
        check("t0 no fu_start", 36'(n_starts - s0), 36'd0);
        read_ch(6, v);
        check("t0 ch6 wrap", 36'(v), 36'h00002);
        read_ch(7, v);
        check("rd_sel 7", 36'(v), 36'd0);
        read_ch(15, v);
        check("rd_sel 15", 36'(v), 36'd0);

        // Start while busy and sticky fu_done at release.
        hold_extra = 1'b1;
        run_case("busy", 17'h04000, 18'h3C000, 9'd2, 1'b1, cyc);
        hold_extra = 1'b0;
        check("protocol", 36'(n_viol), 36'd0);

        // Reset during WAIT of the second round.
        s0 = n_starts;
        dzero = 17'h06000; mu = 18'h30000; times = 9'd3; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        cyc = 0;
        while (!((n_starts - s0) >= NCH + 3 && fu_start) && cyc < 2000) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check("rst2 reached wait", 36'(fu_start), 36'd1);
        #2;
        RST = 1'b1;
        #1;
        check("rst2 fu_start", 36'(fu_start), 36'd0);
        check("rst2 busy", 36'(busy), 36'd0);
        read_ch(0, v);
        check("rst2 ch0", 36'(v), 36'd0);
        read_ch(2, v);
        check("rst2 ch2", 36'(v), 36'd0);
        @(posedge CLK); #2;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        run_case("post", 17'h0C000, 18'h30000, 9'd2, 1'b0, cyc);

        // Unit never answers.
        unit_en = 1'b0;
        dzero = 17'h08000; mu = 18'h20000; times = 9'd1; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(posedge CLK); #1;
            cyc++;
        end
`ifdef LOGISTIC_SCHED_TIMEOUT_EN
        check("to done", 36'(done), 36'd1);
        check("to cycles", 36'(cyc), 36'd14);
        check("to err", 36'(err), 36'd1);
        check("to fu_start", 36'(fu_start), 36'd0);
        @(posedge CLK); #1;
        check("to busy", 36'(busy), 36'd0);
        unit_en = 1'b1;
        run_case("after_to", 17'h08000, 18'h20000, 9'd1, 1'b0, cyc);
        check("to err cleared", 36'(err), 36'd0);
`else
        check("hang busy", 36'(busy), 36'd1);
        check("hang fu_start", 36'(fu_start), 36'd1);
        check("hang err", 36'(err), 36'd0);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b0;
        unit_en = 1'b1;
        @(posedge CLK); #1;
        check("hang recovered", 36'(busy), 36'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
